regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) between NUM_REQ independent writers.
- Typical writers: pipeline writeback, multdiv completion, and the I/O block that updates r25–r29.
- Arbitrates round-robin, registers the winning write one cycle ahead of the register file, and silently drops writes to r0.
- Sits directly in front of regfile; regfile ctrl_reset stays driven by the top level.

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 65 ++++++
 rtl/regfile_write_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the register-file write path: address/data widths,
//   the hard-wired zero register, the I/O-mapped register indices and a small
//   helper used by the write arbiter to spot multi-requester cycles.
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Widest requester vector the arbiter supports; helpers take this width.
  localparam int MAX_REQ    = 8;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Registers owned by the I/O block.
  localparam logic [REG_ADDR_W-1:0] R25 = 5'd25;
  localparam logic [REG_ADDR_W-1:0] R26 = 5'd26;
  localparam logic [REG_ADDR_W-1:0] R27 = 5'd27;
  localparam logic [REG_ADDR_W-1:0] R28 = 5'd28;
  localparam logic [REG_ADDR_W-1:0] R29 = 5'd29;

  // True when at least two bits are set. Clearing the lowest set bit leaves a
  // non-zero value exactly when a second set bit exists.
  function automatic logic atLeastTwoSet(input logic [MAX_REQ-1:0] bits);
    logic [MAX_REQ-1:0] lowCleared;
    lowCleared = bits & (bits - MAX_REQ'(1));
    return (lowCleared != '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Rotating-priority arbiter. The search for a requester starts at rrPtr and
//   walks upward with wrap-around; the first set request wins. When the
//   caller reports that the grant was consumed (advance), the pointer moves
//   to one past the winner so that winner has lowest priority next time.
//
// Ports
//   clock      : rising-edge clock
//   ctrl_reset : asynchronous active-high reset, clears the pointer
//   req        : N request bits
//   advance    : grant accepted this cycle, rotate the pointer
//   grant      : one-hot grant (all zero when no request)
//   grant_idx  : binary index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clock,
  input  logic                 ctrl_reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] rrPtr;
  logic             found;
  int               cand;

  // Candidate index is reduced mod N explicitly so a non-power-of-two N
  // never addresses a grant position that does not exist.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(rrPtr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rrPtr <= '0;
    end else if (advance) begin
      if (grant_idx == IDX_W'(N - 1)) begin
        rrPtr <= '0;
      end else begin
        rrPtr <= grant_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the register file's single write port between NUM_REQ writers
//   (writeback, multdiv completion, I/O block). Requests are arbitrated
//   round-robin in the same cycle, the winning write is registered one cycle
//   ahead of the register file, and writes to r0 are accepted but dropped.
//
// Handshake: a transfer from requester i happens at a rising edge where
//   req_valid[i] and req_ready[i] are both 1. req_ready depends
//   combinationally on req_valid, so requesters must not derive valid from
//   ready, and must hold valid/reg/data stable until accepted.
//
// Ports
//   clock            : rising-edge clock
//   ctrl_reset       : asynchronous active-high reset
//   hold             : suppress new grants (the output register still drains)
//   req_valid        : per-requester write request
//   req_reg          : destination, requester i at [5i+4:5i]
//   req_data         : data, requester i at [32i+31:32i]
//   req_ready        : one-hot grant
//   ctrl_writeEnable : registered write strobe to the register file
//   ctrl_writeReg    : registered destination register
//   data_writeReg    : registered write data
//   drop_count       : saturating count of accepted writes to r0
//   conflict_count   : saturating count of un-held cycles with >=2 requests
// ---------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16
) (
  input  logic                          clock,
  input  logic                          ctrl_reset,
  input  logic                          hold,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_reg,
  input  logic [DATA_W*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]             data_writeReg,
  output logic [CNT_W-1:0]              drop_count,
  output logic [CNT_W-1:0]              conflict_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    arbGrant;
  logic [IDX_W-1:0]      grantIdx;
  logic                  transfer;
  logic [REG_ADDR_W-1:0] selReg;
  logic [DATA_W-1:0]     selData;
  logic                  selIsZero;
  logic                  conflictCycle;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rrArbiter (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .req        (req_valid),
    .advance    (transfer),
    .grant      (arbGrant),
    .grant_idx  (grantIdx)
  );

  // Grants are masked (not the request vector) so the pointer only rotates
  // when a grant is actually visible to a requester.
  assign req_ready = (ctrl_reset || hold) ? '0 : arbGrant;
  assign transfer  = |(req_valid & req_ready);

  assign selReg    = req_reg[int'(grantIdx)*REG_ADDR_W +: REG_ADDR_W];
  assign selData   = req_data[int'(grantIdx)*DATA_W +: DATA_W];
  assign selIsZero = (selReg == REG_ZERO);

  assign conflictCycle = !hold && atLeastTwoSet(MAX_REQ'(req_valid));

  // Output stage: one register, no queue. Destination and data only change
  // on a real (non-r0) write so the bus keeps showing the last committed one.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= REG_ZERO;
      data_writeReg    <= '0;
    end else begin
      ctrl_writeEnable <= transfer && !selIsZero;
      if (transfer && !selIsZero) begin
        ctrl_writeReg <= selReg;
        data_writeReg <= selData;
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      drop_count <= '0;
    end else if (transfer && selIsZero && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      conflict_count <= '0;
    end else if (conflictCycle && (conflict_count != '1)) begin
      conflict_count <= conflict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int NR = 3;
  localparam int CW = 4;
  localparam int NV = 18;

  // ---------------- clock / reset / DUT ----------------
  logic            clock = 1'b0;
  logic            ctrl_reset;
  logic            hold;
  logic [NR-1:0]   req_valid;
  logic [5*NR-1:0] req_reg;
  logic [32*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            ctrl_writeEnable;
  logic [4:0]      ctrl_writeReg;
  logic [31:0]     data_writeReg;
  logic [CW-1:0]   drop_count;
  logic [CW-1:0]   conflict_count;

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .NUM_REQ (NR),
    .CNT_W   (CW)
  ) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .hold             (hold),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .drop_count       (drop_count),
    .conflict_count   (conflict_count)
  );

  // Downstream register-file storage (r0 hard-wired to zero).
  logic [31:0] rf [0:31] = '{default: 32'h0};
  always @(posedge clock) begin
    if (ctrl_writeEnable && ctrl_writeReg != 5'd0) rf[ctrl_writeReg] <= data_writeReg;
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (!ctrl_reset && ctrl_writeEnable) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_write: got reg %0d data 0x%0h expected no write",
                 ctrl_writeReg, data_writeReg);
      end else begin
        exp_word = exp_q.pop_front();
        check("sb_write", 64'({ctrl_writeReg, data_writeReg}), 64'(exp_word));
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0]  valid;
    logic        hold_v;
    logic [14:0] regs;
    logic [95:0] data;
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_conf;
    logic [3:0]  exp_drop;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic [2:0] valid, input logic hold_v,
                              input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] rdy, input logic we, input logic [4:0] wreg,
                              input logic [31:0] wdata, input logic [3:0] conf, input logic [3:0] drop);
    vec_t v;
    v.valid = valid; v.hold_v = hold_v;
    v.regs = {r2, r1, r0}; v.data = {d2, d1, d0};
    v.exp_ready = rdy; v.exp_we = we; v.exp_wreg = wreg; v.exp_wdata = wdata;
    v.exp_conf = conf; v.exp_drop = drop;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_valid = v.valid;
    hold      = v.hold_v;
    req_reg   = v.regs;
    req_data  = v.data;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF, A7 = 32'hA5A50007;
  localparam logic [31:0] D1 = 32'h11111111, D2 = 32'h22222222, D3 = 32'h33333333;
  localparam logic [31:0] DA = 32'hAAAA0026, DBB = 32'hBBBB0026, D9 = 32'h00000099;

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  er;
    logic [4:0]  r;
    logic [31:0] d;
    vec_t        v;

    // single writer, pointer back to 0, round-robin, r0 drop, hold+collision
    vecs[0]  = mk(3'b001,0, 5,0,0, DB,0,0,        3'b001, 0,0,0,      0,0);
    vecs[1]  = mk(3'b000,0, 0,0,0, 0,0,0,         3'b000, 1,5,DB,     0,0);
    vecs[2]  = mk(3'b100,0, 0,0,7, 0,0,A7,        3'b100, 0,5,DB,     0,0);
    vecs[3]  = mk(3'b111,0, 1,2,3, D1,D2,D3,      3'b001, 1,7,A7,     0,0);
    vecs[4]  = mk(3'b111,0, 1,2,3, D1,D2,D3,      3'b010, 1,1,D1,     1,0);
    vecs[5]  = mk(3'b111,0, 1,2,3, D1,D2,D3,      3'b100, 1,2,D2,     2,0);
    vecs[6]  = mk(3'b111,0, 1,2,3, D1,D2,D3,      3'b001, 1,3,D3,     3,0);
    vecs[7]  = mk(3'b111,0, 1,2,3, D1,D2,D3,      3'b010, 1,1,D1,     4,0);
    vecs[8]  = mk(3'b111,0, 1,2,3, D1,D2,D3,      3'b100, 1,2,D2,     5,0);
    vecs[9]  = mk(3'b010,0, 0,0,0, 0,32'h1234,0,  3'b010, 1,3,D3,     6,0);
    vecs[10] = mk(3'b100,0, 0,0,9, 0,0,D9,        3'b100, 0,3,D3,     6,1);
    vecs[11] = mk(3'b101,1, 26,0,26, DA,0,DBB,    3'b000, 1,9,D9,     6,1);
    vecs[12] = mk(3'b101,1, 26,0,26, DA,0,DBB,    3'b000, 0,9,D9,     6,1);
    vecs[13] = mk(3'b101,1, 26,0,26, DA,0,DBB,    3'b000, 0,9,D9,     6,1);
    vecs[14] = mk(3'b101,0, 26,0,26, DA,0,DBB,    3'b001, 0,9,D9,     6,1);
    vecs[15] = mk(3'b100,0, 26,0,26, DA,0,DBB,    3'b100, 1,26,DA,    7,1);
    vecs[16] = mk(3'b000,0, 0,0,0, 0,0,0,         3'b000, 1,26,DBB,   7,1);
    vecs[17] = mk(3'b000,0, 0,0,0, 0,0,0,         3'b000, 0,26,DBB,   7,1);

    ctrl_reset = 1'b0; hold = 1'b0;
    req_valid = '0; req_reg = '0; req_data = '0;
    #1 ctrl_reset = 1'b1;
    req_valid = 3'b111;
    req_reg   = {5'd3, 5'd2, 5'd1};
    @(negedge clock);
    check("rst_ready", 64'(req_ready), 64'(3'b000));
    check("rst_we",    64'(ctrl_writeEnable), 64'(0));
    check("rst_wreg",  64'(ctrl_writeReg), 64'(0));
    check("rst_wdata", 64'(data_writeReg), 64'(0));
    check("rst_drop",  64'(drop_count), 64'(0));
    check("rst_conf",  64'(conflict_count), 64'(0));
    @(posedge clock); #1;
    ctrl_reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v);
      @(negedge clock);
      check($sformatf("v%0d_ready", i), 64'(req_ready), 64'(v.exp_ready));
      check($sformatf("v%0d_we", i),    64'(ctrl_writeEnable), 64'(v.exp_we));
      check($sformatf("v%0d_wreg", i),  64'(ctrl_writeReg), 64'(v.exp_wreg));
      check($sformatf("v%0d_wdata", i), 64'(data_writeReg), 64'(v.exp_wdata));
      check($sformatf("v%0d_conf", i),  64'(conflict_count), 64'(v.exp_conf));
      check($sformatf("v%0d_drop", i),  64'(drop_count), 64'(v.exp_drop));
      for (int j = 0; j < NR; j++) begin
        r = v.regs[j*5 +: 5];
        d = v.data[j*32 +: 32];
        if (v.exp_ready[j] && r != 5'd0) exp_q.push_back({r, d});
      end
      @(posedge clock); #1;
    end

    check("rf_r5",  64'(rf[5]),  64'(DB));
    check("rf_r7",  64'(rf[7]),  64'(A7));
    check("rf_r3",  64'(rf[3]),  64'(D3));
    check("rf_r9",  64'(rf[9]),  64'(D9));
    check("rf_r26", 64'(rf[26]), 64'(DBB));

    // Saturation: every cycle is a conflict and an r0 drop (pointer starts at 0).
    for (int i = 0; i < 19; i++) begin
      req_valid = 3'b111; hold = 1'b0;
      req_reg   = '0;
      req_data  = {3{32'(i)}};
      @(negedge clock);
      er = 3'b001 << (i % 3);
      check($sformatf("sat%0d_ready", i), 64'(req_ready), 64'(er));
      check($sformatf("sat%0d_we", i), 64'(ctrl_writeEnable), 64'(0));
      @(posedge clock); #1;
    end

    // Reset mid-operation; pointer is at 1 after 19 grants.
    req_valid = 3'b111;
    req_reg   = {5'd20, 5'd20, 5'd20};
    req_data  = {32'hC2C20020, 32'hC1C10020, 32'hC0C00020};
    @(negedge clock);
    check("sat_conf", 64'(conflict_count), 64'(4'hF));
    check("sat_drop", 64'(drop_count), 64'(4'hF));
    check("pre_rst_ready", 64'(req_ready), 64'(3'b010));
    exp_q.push_back({5'd20, 32'hC1C10020});
    @(posedge clock); #1;
    @(negedge clock);
    check("inflight_we", 64'(ctrl_writeEnable), 64'(1));
    #2 ctrl_reset = 1'b1;
    #1;
    check("midrst_we",    64'(ctrl_writeEnable), 64'(0));
    check("midrst_wreg",  64'(ctrl_writeReg), 64'(0));
    check("midrst_wdata", 64'(data_writeReg), 64'(0));
    check("midrst_conf",  64'(conflict_count), 64'(0));
    check("midrst_drop",  64'(drop_count), 64'(0));
    check("midrst_ready", 64'(req_ready), 64'(3'b000));
    @(posedge clock); #1;
    ctrl_reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 64'(req_ready), 64'(3'b001));
    check("discarded_r20",  64'(rf[20]), 64'(0));
    exp_q.push_back({5'd20, 32'hC0C00020});
    @(posedge clock); #1;
    req_valid = 3'b000;
    @(posedge clock); #1;
    @(negedge clock);
    check("rf_r20", 64'(rf[20]), 64'(32'hC0C00020));

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
